// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, NOP payload, control bundle type and counter helper for pipeline stages
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
   localparam logic [31:0] NOP = 32'h00000013;
   typedef struct packed {
      logic [3:0] wb;
      logic [3:0] mem;
      logic [7:0] ex;
   } ctrl_t;
   localparam ctrl_t CTRL_ZERO = '0;
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/pipe_skid_ctrl.sv
// pipe_skid_ctrl: EMPTY/BUSY/FULL handshake FSM with registered in_ready and datapath load enables
module pipe_skid_ctrl
   import pipe_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic out_ready,
   input  logic hold,
   input  logic flush,
   output logic in_ready,
   output logic out_valid,
   output logic ld_main,
   output logic ld_skid,
   output logic mv_skid
);
   state_t state, nxt;
   logic acc, dlv;
   // state register; in_ready is registered from the next state so it drops together with entering FULL
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         state <= nxt;
         in_ready <= nxt != FULL;
      end
   assign out_valid = state != EMPTY;
   // next state and enables; flush empties the stage without touching storage
   always_comb begin
      acc = in_valid & in_ready & ~flush;
      dlv = out_valid & out_ready & ~hold;
      nxt = state;
      ld_main = 1'b0;
      ld_skid = 1'b0;
      mv_skid = 1'b0;
      if (flush) nxt = EMPTY;
      else case (state)
         EMPTY: begin
            ld_main = acc;
            nxt = acc ? BUSY : EMPTY;
         end
         BUSY: begin
            ld_main = acc & dlv;
            ld_skid = acc & ~dlv;
            nxt = (acc & ~dlv) ? FULL : (~acc & dlv) ? EMPTY : BUSY;
         end
         FULL: begin
            mv_skid = dlv;
            nxt = dlv ? BUSY : FULL;
         end
         default: nxt = EMPTY;
      endcase
   end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready pipeline register with 2-entry skid, flush and hold; PIPE_STAGE_PERF_EN adds stall/flush counters
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int          CTRL_W      = 16,
   parameter int          PC_W        = 32,
   parameter logic [31:0] BUBBLE_DATA = NOP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              hold,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [PC_W-1:0]   out_pc
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);
   logic ld_main, ld_skid, mv_skid;
   logic [DATA_W-1:0] main_data, skid_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [PC_W-1:0]   main_pc, skid_pc;

   pipe_skid_ctrl u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .hold      (hold),
      .flush     (flush),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .ld_main   (ld_main),
      .ld_skid   (ld_skid),
      .mv_skid   (mv_skid)
   );

   // payload storage: main takes a fresh beat or the older skid beat; skid only catches the overflow beat
   always_ff @(posedge clk) begin
      if (ld_main) begin
         main_data <= in_data;
         main_ctrl <= in_ctrl;
         main_pc   <= in_pc;
      end else if (mv_skid) begin
         main_data <= skid_data;
         main_ctrl <= skid_ctrl;
         main_pc   <= skid_pc;
      end
      if (ld_skid) begin
         skid_data <= in_data;
         skid_ctrl <= in_ctrl;
         skid_pc   <= in_pc;
      end
   end

   assign out_data = out_valid ? main_data : DATA_W'(BUBBLE_DATA);
   assign out_ctrl = out_valid ? main_ctrl : CTRL_W'(CTRL_ZERO);
   assign out_pc   = out_valid ? main_pc : '0;

`ifdef PIPE_STAGE_PERF_EN
   // saturating counters of stalled output cycles and of flushes that actually discard something
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid & (~out_ready | hold)) stall_cnt <= sat_inc(stall_cnt);
         if (flush & (out_valid | in_valid)) flush_cnt <= sat_inc(flush_cnt);
      end
`else
`endif
endmodule
